wb_b3_burst_ram: RTL and testbench

- Wishbone B3 slave RAM that sits directly downstream of the three-master RAM arbiter and is the memory that arbiter feeds.
- Serves classic single accesses and incrementing bursts (linear, wrap-4, wrap-8, wrap-16) with byte selects.
- Registered acknowledge. After the first beat, a burst streams one beat per clock.
- Out-of-range addresses are flagged with wb_err_o.

---
 rtl/wb_b3_burst_ram_if.sv | 29 ++
 rtl/wb_b3_burst_ram.sv | 124 ++++++++++++
 tb/tb_wb_b3_burst_ram.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_b3_burst_ram_if.sv
// Wishbone B3 bus bundle between a master (arbiter) and the burst RAM slave.
// Signal names follow the slave's view of the bus (_i into the RAM, _o out of it).
interface wb_b3_burst_ram_if #(
  parameter int aw = 32,
  parameter int dw = 32
);
  logic [aw-1:0] wb_adr_i;
  logic [dw-1:0] wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;
  logic [dw-1:0] wb_dat_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );
endinterface

// File: rtl/wb_b3_burst_ram.sv
// Wishbone B3 slave RAM with registered ack, classic and incrementing/wrapping bursts,
// byte selects, and an error response for addresses beyond the memory size.
module wb_b3_burst_ram #(
  parameter int          aw             = 32,
  parameter int          dw             = 32,
  parameter int unsigned mem_size_bytes = 32'h0000_0400,
  parameter int          mem_adr_width  = 10,
  parameter string       memory_file    = ""
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_b3_burst_ram_if.slave wb
);

  localparam int unsigned   MemWords = mem_size_bytes / 4;
  localparam logic [aw-1:0] MemLimit = aw'(mem_size_bytes);

  typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic          r_ack;
  logic          r_err;
  logic [dw-1:0] r_dat;
  logic [aw-1:0] r_pred;
  logic [dw-1:0] r_mem [0:MemWords-1];

  logic          w_req;
  logic          w_match;
  logic          w_ack;
  logic          w_err;
  logic          w_load;
  logic [aw-1:0] w_loadAdr;
  logic          w_loadInRange;
  logic          w_wrInRange;
  logic          w_nextAck;
  logic          w_nextErr;
  logic [aw-1:0] w_nextPred;

  // Wrap modes only advance the word index inside the aligned 4/8/16-word block.
  function automatic logic [aw-1:0] nextAdr(input logic [aw-1:0] p, input logic [1:0] bte);
    nextAdr = p + aw'(4);
    case (bte)
      2'b01:   nextAdr = {p[aw-1:4], p[3:2] + 2'd1, p[1:0]};
      2'b10:   nextAdr = {p[aw-1:5], p[4:2] + 3'd1, p[1:0]};
      2'b11:   nextAdr = {p[aw-1:6], p[5:2] + 4'd1, p[1:0]};
      default: nextAdr = p + aw'(4);
    endcase
  endfunction

  assign w_req         = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_match       = (r_state != BURST) || (wb.wb_adr_i == r_pred);
  assign w_ack         = r_ack & w_req & w_match;
  assign w_err         = r_err & w_req & w_match;
  assign w_loadInRange = w_loadAdr < MemLimit;
  assign w_wrInRange   = wb.wb_adr_i < MemLimit;

  assign wb.wb_ack_o = w_ack;
  assign wb.wb_err_o = w_err;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = r_dat;

  always_comb begin
    w_nextState = IDLE;
    w_load      = 1'b0;
    w_loadAdr   = wb.wb_adr_i;
    w_nextPred  = r_pred;
    w_nextAck   = 1'b0;
    w_nextErr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_load      = 1'b1;
          w_nextPred  = wb.wb_adr_i;
          w_nextState = (wb.wb_cti_i == 3'b010) ? BURST : SINGLE;
        end
      end
      // Prefetch the next beat while the current one is being acknowledged.
      BURST: begin
        if (w_req && w_match && (wb.wb_cti_i != 3'b111)) begin
          w_load      = 1'b1;
          w_loadAdr   = nextAdr(r_pred, wb.wb_bte_i);
          w_nextPred  = w_loadAdr;
          w_nextState = BURST;
        end
      end
      default: ;
    endcase
    if (w_load) begin
      w_nextAck = w_loadInRange;
      w_nextErr = ~w_loadInRange;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_pred  <= '0;
    end else begin
      r_state <= w_nextState;
      r_ack   <= w_nextAck;
      r_err   <= w_nextErr;
      r_pred  <= w_nextPred;
      if (w_load && w_loadInRange) begin
        r_dat <= r_mem[w_loadAdr[mem_adr_width-1:2]];
      end
    end
  end

  // A write lands only on an acknowledged beat; reset suppresses it.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && w_ack && wb.wb_we_i && w_wrInRange) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.wb_sel_i[b]) begin
          r_mem[wb.wb_adr_i[mem_adr_width-1:2]][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_b3_burst_ram.sv
// Self-checking bench for wb_b3_burst_ram: directed Wishbone sequences plus randomized
// classic/burst traffic, compared against a word-array reference of the memory.
module tb_wb_b3_burst_ram;

  localparam logic [31:0] MemSize = 32'h0000_0400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCompared   = 0;
  int   nMismatched = 0;
  logic [31:0] refMem [0:255];

  always #5 clk = ~clk;

  wb_b3_burst_ram_if #(.aw(32), .dw(32)) bus ();

  wb_b3_burst_ram dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cyc, input logic stb, input logic [31:0] adr,
                               input logic [2:0] cti, input logic [1:0] bte, input logic we,
                               input logic [3:0] sel, input logic [31:0] dat);
    @(posedge clk);
    #1;
    bus.wb_cyc_i = cyc;
    bus.wb_stb_i = stb;
    bus.wb_adr_i = adr;
    bus.wb_cti_i = cti;
    bus.wb_bte_i = bte;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat;
  endtask

  // Next burst address from the Wishbone rules: linear +4, or +4 modulo the wrap block size.
  function automatic logic [31:0] refNext(input logic [31:0] a, input logic [1:0] bte);
    logic [31:0] blk;
    logic [31:0] base;
    if (bte == 2'b00) return a + 32'd4;
    blk  = 32'd8 << bte;
    base = a - (a % blk);
    return base + ((a - base + 32'd4) % blk);
  endfunction

  function automatic void refWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) refMem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  task automatic classicAccess(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                               input logic [31:0] dat, input string tag);
    logic expErr;
    expErr = adr >= MemSize;
    applyStimulus(1'b1, 1'b1, adr, 3'b000, 2'b00, we, sel, dat);
    @(negedge clk);
    checkOutput({tag, " req ack"}, 32'(bus.wb_ack_o), 32'd0);
    checkOutput({tag, " req err"}, 32'(bus.wb_err_o), 32'd0);
    applyStimulus(1'b1, 1'b1, adr, 3'b000, 2'b00, we, sel, dat);
    @(negedge clk);
    checkOutput({tag, " ack"}, 32'(bus.wb_ack_o), 32'(!expErr));
    checkOutput({tag, " err"}, 32'(bus.wb_err_o), 32'(expErr));
    if (!expErr) begin
      if (we) refWrite(adr, dat, sel);
      else    checkOutput({tag, " rdata"}, bus.wb_dat_o, refMem[adr[9:2]]);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 3'b000, 2'b00, 1'b0, 4'h0, 32'd0);
    @(negedge clk);
    checkOutput({tag, " ack after"}, 32'(bus.wb_ack_o), 32'd0);
  endtask

  // Burst of n beats; gapAfter > 0 drops stb for two cycles after that many beats.
  task automatic runBurst(input logic [31:0] start, input logic [1:0] bte, input int n,
                          input logic we, input int gapAfter, input bit idxData, input string tag);
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  sel;
    logic        expErr;
    bit          needReq;
    int          k;
    a       = start;
    k       = 0;
    needReq = 1'b1;
    wd      = idxData ? (a >> 2) : $urandom;
    sel     = (idxData || !we) ? 4'hF : 4'($urandom_range(1, 15));
    while (k < n) begin
      applyStimulus(1'b1, 1'b1, a, (k == n-1) ? 3'b111 : 3'b010, bte, we, sel, wd);
      @(negedge clk);
      if (needReq) begin
        checkOutput({tag, " first-beat ack"}, 32'(bus.wb_ack_o), 32'd0);
        checkOutput({tag, " first-beat err"}, 32'(bus.wb_err_o), 32'd0);
        needReq = 1'b0;
      end else begin
        expErr = a >= MemSize;
        checkOutput({tag, " beat ack"}, 32'(bus.wb_ack_o), 32'(!expErr));
        checkOutput({tag, " beat err"}, 32'(bus.wb_err_o), 32'(expErr));
        if (!expErr) begin
          if (we) refWrite(a, wd, sel);
          else    checkOutput({tag, " beat data"}, bus.wb_dat_o, refMem[a[9:2]]);
        end
        k++;
        a   = refNext(a, bte);
        wd  = idxData ? (a >> 2) : $urandom;
        sel = (idxData || !we) ? 4'hF : 4'($urandom_range(1, 15));
        if (k == gapAfter && k < n) begin
          repeat (2) begin
            applyStimulus(1'b1, 1'b0, a, 3'b010, bte, we, sel, wd);
            @(negedge clk);
            checkOutput({tag, " gap ack"}, 32'(bus.wb_ack_o), 32'd0);
          end
          needReq = 1'b1;
        end
      end
    end
    applyStimulus(1'b1, 1'b1, a, 3'b111, bte, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    checkOutput({tag, " post ack"}, 32'(bus.wb_ack_o), 32'd0);
    checkOutput({tag, " post err"}, 32'(bus.wb_err_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 3'b000, 2'b00, 1'b0, 4'h0, 32'd0);
    @(negedge clk);
    checkOutput({tag, " idle ack"}, 32'(bus.wb_ack_o), 32'd0);
  endtask

  initial begin
    logic [31:0] start;
    logic [31:0] x0;
    int          kind;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_cti_i = '0;
    bus.wb_bte_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = '0;
    bus.wb_dat_i = '0;
    for (int i = 0; i < 256; i++) refMem[i] = 32'hx;

    $display("[TB] reset");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus(1'b0, 1'b0, 32'd0, 3'b000, 2'b00, 1'b0, 4'h0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset ack", 32'(bus.wb_ack_o), 32'd0);
    checkOutput("reset err", 32'(bus.wb_err_o), 32'd0);
    checkOutput("reset rty", 32'(bus.wb_rty_o), 32'd0);
    checkOutput("reset dat", bus.wb_dat_o, 32'd0);

    $display("[TB] preload word index");
    runBurst(32'h0, 2'b00, 256, 1'b1, -1, 1'b1, "preload");

    $display("[TB] directed bursts");
    runBurst(32'h20, 2'b00, 4, 1'b0, -1, 1'b0, "linear4");
    runBurst(32'h0C, 2'b01, 4, 1'b0, -1, 1'b0, "wrap4");
    runBurst(32'h38, 2'b10, 8, 1'b0, -1, 1'b0, "wrap8");
    runBurst(32'h74, 2'b11, 16, 1'b0, -1, 1'b0, "wrap16");

    $display("[TB] classic accesses");
    classicAccess(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, "wr deadbeef");
    classicAccess(32'h10, 1'b0, 4'hF, 32'd0, "rd deadbeef");
    checkOutput("held deadbeef", bus.wb_dat_o, 32'hDEADBEEF);
    classicAccess(32'h10, 1'b1, 4'b0001, 32'h000000AA, "wr byte0");
    classicAccess(32'h10, 1'b0, 4'hF, 32'd0, "rd byte0");
    checkOutput("held deadbeaa", bus.wb_dat_o, 32'hDEADBEAA);
    classicAccess(32'h400, 1'b0, 4'hF, 32'd0, "rd out of range");
    classicAccess(32'h400, 1'b1, 4'hF, 32'h12345678, "wr out of range");

    $display("[TB] disturbances");
    runBurst(32'h40, 2'b00, 6, 1'b0, 2, 1'b0, "stb gap");
    runBurst(32'h3F8, 2'b00, 4, 1'b1, -1, 1'b0, "cross limit wr");

    x0 = 32'hA5A5_0080;
    applyStimulus(1'b1, 1'b1, 32'h80, 3'b010, 2'b00, 1'b1, 4'hF, x0);
    @(negedge clk);
    checkOutput("rst burst req ack", 32'(bus.wb_ack_o), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h80, 3'b010, 2'b00, 1'b1, 4'hF, x0);
    @(negedge clk);
    checkOutput("rst burst beat0 ack", 32'(bus.wb_ack_o), 32'd1);
    refWrite(32'h80, x0, 4'hF);
    applyStimulus(1'b1, 1'b1, 32'h84, 3'b010, 2'b00, 1'b1, 4'hF, 32'h5A5A_0084);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h88, 3'b010, 2'b00, 1'b0, 4'hF, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after rst ack", 32'(bus.wb_ack_o), 32'd0);
    checkOutput("after rst err", 32'(bus.wb_err_o), 32'd0);
    checkOutput("after rst dat", bus.wb_dat_o, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 3'b000, 2'b00, 1'b0, 4'h0, 32'd0);
    @(negedge clk);
    checkOutput("after rst idle ack", 32'(bus.wb_ack_o), 32'd0);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) start = 32'h3F0 + 32'(4 * $urandom_range(0, 7));
      else                           start = 32'(4 * $urandom_range(0, 255));
      if (kind == 0) begin
        classicAccess(start, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, "rnd classic");
      end else begin
        runBurst(start, 2'($urandom_range(0, 3)), $urandom_range(2, 8), 1'($urandom_range(0, 1)),
                 (kind == 2) ? $urandom_range(1, 3) : -1, 1'b0, "rnd burst");
      end
    end

    $display("[TB] full readback");
    runBurst(32'h0, 2'b00, 256, 1'b0, -1, 1'b0, "readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
